// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types and constants.
// Holds the scheduler FSM encoding and a width helper.
package ldpc_pkg;

  localparam int LDPC_N_ROWS = 64;
  localparam int LDPC_IT_W   = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } sched_st_t;

  // Never returns 0 so a one-row config still gets a 1-bit address.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cnu_sched_if.sv
// Scheduler bundle: decode control plus q/r memory and CNU strobes.
// master = scheduler side, slave = control/datapath side.
interface cnu_sched_if
  import ldpc_pkg::*;
#(
  parameter int N_ROWS = LDPC_N_ROWS,
  parameter int IT_W   = LDPC_IT_W
) ();

  localparam int ROW_W = clog2(N_ROWS);

  logic             start;
  logic [IT_W-1:0]  max_iter;
  logic             stall;
  logic             syn_ok;
  logic             rd_en;
  logic [ROW_W-1:0] rd_addr;
  logic             cnu_en;
  logic             wr_en;
  logic [ROW_W-1:0] wr_addr;
  logic [IT_W-1:0]  iter;
  logic             busy;
  logic             done;
  logic             early;

  modport master (
    input  start, max_iter, stall, syn_ok,
    output rd_en, rd_addr, cnu_en, wr_en,
    output wr_addr, iter, busy, done, early
  );

  modport slave (
    output start, max_iter, stall, syn_ok,
    input  rd_en, rd_addr, cnu_en, wr_en,
    input  wr_addr, iter, busy, done, early
  );

endinterface

// File: rtl/cnu_flight.sv
// In-flight row tracker: {valid, row} shift line through
// the q-read and CNU stages, tail feeds the r-memory write.
module cnu_flight #(
  parameter int RD_LAT  = 1,
  parameter int CNU_LAT = 1,
  parameter int AW      = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_v,
  input  logic [AW-1:0] i_addr,
  output logic          o_cnu_en,
  output logic          o_v,
  output logic [AW-1:0] o_addr,
  output logic          o_empty
);

  localparam int L = RD_LAT + CNU_LAT;

  logic [L-1:0]  r_v;
  logic [AW-1:0] r_a [L];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      for (int i = 0; i < L; i++) r_a[i] <= '0;
    end else begin
      r_v    <= {r_v[L-2:0], i_v};
      r_a[0] <= i_addr;
      for (int i = 1; i < L; i++) r_a[i] <= r_a[i-1];
    end
  end

  assign o_cnu_en = |r_v[L-2:RD_LAT-1];
  assign o_v      = r_v[L-1];
  assign o_addr   = r_a[L-1];
  // Only the tail may hold a row: line is empty after this edge.
  assign o_empty  = ~|r_v[L-2:0];

endmodule

// File: rtl/cnu_sched.sv
// Check-node row scheduler: issues q reads row by row,
// tracks rows through the CNU and closes each iteration.
module cnu_sched
  import ldpc_pkg::*;
#(
  parameter int D       = 8,
  parameter int N_ROWS  = LDPC_N_ROWS,
  parameter int CNU_LAT = 1,
  parameter int RD_LAT  = 1,
  parameter int IT_W    = LDPC_IT_W
) (
  input logic         clk,
  input logic         rst,
  cnu_sched_if.master bus
);

  localparam int ROW_W = clog2(N_ROWS);
  localparam logic [ROW_W-1:0] LAST = ROW_W'(N_ROWS - 1);

  sched_st_t        r_state;
  logic [ROW_W-1:0] r_row;
  logic [IT_W-1:0]  r_iter;
  logic [IT_W-1:0]  r_limit;
  logic             r_busy;
  logic             r_done;
  logic             r_early;

  logic             w_issue;
  logic             w_cnu_en;
  logic             w_tail_v;
  logic [ROW_W-1:0] w_tail_a;
  logic             w_empty;

  if (N_ROWS < 2 || CNU_LAT < 1 || RD_LAT != 1 || D < 1)
  begin : g_bad_cfg
    $error("cnu_sched: unsupported parameters");
  end

  assign w_issue = (r_state == S_RUN) && !bus.stall;

  cnu_flight #(
    .RD_LAT  (RD_LAT),
    .CNU_LAT (CNU_LAT),
    .AW      (ROW_W)
  ) u_flight (
    .clk      (clk),
    .rst      (rst),
    .i_v      (w_issue),
    .i_addr   (r_row),
    .o_cnu_en (w_cnu_en),
    .o_v      (w_tail_v),
    .o_addr   (w_tail_a),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_iter  <= '0;
      r_limit <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_early <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_limit <= (bus.max_iter == '0) ? IT_W'(1)
                                            : bus.max_iter;
            r_iter  <= '0;
            r_row   <= '0;
            r_early <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            if (r_row == LAST) begin
              r_row   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_empty) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.syn_ok) begin
            r_early <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_iter == r_limit - IT_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_iter  <= r_iter + 1'b1;
            r_state <= S_RUN;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en   = w_issue;
  assign bus.rd_addr = r_row;
  assign bus.cnu_en  = w_cnu_en;
  assign bus.wr_en   = w_tail_v;
  assign bus.wr_addr = w_tail_a;
  assign bus.iter    = r_iter;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.early   = r_early;

endmodule

// File: tb/tb_cnu_sched.sv
// Directed bench for cnu_sched: 4-row configs with CNU_LAT 1 and 3.
// Per-cycle vector tables plus reset and long-latency sequences.
module tb_cnu_sched;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cnu_sched_if #(.N_ROWS(4), .IT_W(6)) b0 ();
  cnu_sched_if #(.N_ROWS(4), .IT_W(6)) b1 ();

  cnu_sched #(
    .D(8), .N_ROWS(4), .CNU_LAT(1), .RD_LAT(1), .IT_W(6)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  cnu_sched #(
    .D(8), .N_ROWS(4), .CNU_LAT(3), .RD_LAT(1), .IT_W(6)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic [5:0] mi;
    logic       sl;
    logic       sy;
    logic       rd;
    logic [1:0] ra;
    logic       ce;
    logic       we;
    logic [1:0] wa;
    logic [5:0] it;
    logic       bz;
    logic       dn;
    logic       er;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    int st, int mi, int sl, int sy, int rd, int ra, int ce,
    int we, int wa, int it, int bz, int dn, int er);
    vec_t v;
    v.st = st[0]; v.mi = mi[5:0]; v.sl = sl[0]; v.sy = sy[0];
    v.rd = rd[0]; v.ra = ra[1:0]; v.ce = ce[0]; v.we = we[0];
    v.wa = wa[1:0]; v.it = it[5:0]; v.bz = bz[0];
    v.dn = dn[0]; v.er = er[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] b0_all();
    return {b0.rd_en, b0.rd_addr, b0.cnu_en, b0.wr_en, b0.wr_addr,
            b0.iter, b0.busy, b0.done, b0.early};
  endfunction

  initial begin
    logic [15:0] act;
    logic [15:0] exp;
    logic [1:0]  wa_a;
    logic        e_ce, e_we, e_bz, e_dn;
    logic [1:0]  e_wa;
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    b0.start = 0; b0.max_iter = 0; b0.stall = 0; b0.syn_ok = 0;
    b1.start = 0; b1.max_iter = 0; b1.stall = 0; b1.syn_ok = 0;

    // st mi sl sy | rd ra ce we wa it bz dn er
    // A: two iterations, no early exit, start pulses while busy
    vq.push_back(mk(1,2,0,0, 0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,2,0,0, 1,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,1,1,0,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,2,1,1,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,3,1,1,1, 0,1,0,0));
    vq.push_back(mk(1,2,0,0, 0,0,1,1,2, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,1,3, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(1,2,0,0, 1,1,1,0,0, 1,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,2,1,1,0, 1,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,3,1,1,1, 1,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,1,1,2, 1,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,1,3, 1,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,0,0, 1,0,1,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,0,0, 1,0,0,0));
    // B: syn_ok in DRAIN ignored, syn_ok in CHECK ends early
    vq.push_back(mk(1,2,0,0, 0,0,0,0,0, 1,0,0,0));
    vq.push_back(mk(0,2,0,0, 1,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,1,1,0,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,2,1,1,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 1,3,1,1,1, 0,1,0,0));
    vq.push_back(mk(0,2,0,1, 0,0,1,1,2, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,1,3, 0,1,0,0));
    vq.push_back(mk(0,2,0,1, 0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,2,0,0, 0,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(0,2,0,0, 0,0,0,0,0, 0,0,0,1));
    // C: max_iter=0, stall in IDLE/DRAIN ignored, stall in RUN
    vq.push_back(mk(1,0,1,0, 0,0,0,0,0, 0,0,0,1));
    vq.push_back(mk(0,0,0,0, 1,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,1,0, 0,1,1,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,1,0, 0,1,0,1,0, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,2,1,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 1,3,1,1,1, 0,1,0,0));
    vq.push_back(mk(0,0,1,0, 0,0,1,1,2, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,1,3, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,1,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_u0", {16'h0, b0_all()}, 32'h0);
    chk("reset_u1", {29'h0, b1.busy, b1.cnu_en, b1.wr_en}, 32'h0);
    rst = 1'b1;
    step();

    foreach (vq[i]) begin
      b0.start    = vq[i].st;
      b0.max_iter = vq[i].mi;
      b0.stall    = vq[i].sl;
      b0.syn_ok   = vq[i].sy;
      #1;
      wa_a = vq[i].we ? b0.wr_addr : vq[i].wa;
      act = {b0.rd_en, b0.rd_addr, b0.cnu_en, b0.wr_en, wa_a,
             b0.iter, b0.busy, b0.done, b0.early};
      exp = {vq[i].rd, vq[i].ra, vq[i].ce, vq[i].we, vq[i].wa,
             vq[i].it, vq[i].bz, vq[i].dn, vq[i].er};
      chk($sformatf("vec%0d", i), {16'h0, act}, {16'h0, exp});
      step();
    end
    b0.start = 0; b0.stall = 0; b0.syn_ok = 0;

    // Reset while row 2 sits in the tracker
    b0.start = 1; b0.max_iter = 6'd3;
    step();
    b0.start = 0;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_async", {16'h0, b0_all()}, 32'h0);
    step();
    chk("rst_hold", {16'h0, b0_all()}, 32'h0);
    rst = 1'b1;
    b0.start = 1; b0.max_iter = 6'd1;
    #1;
    chk("restart_c0_rd", {31'h0, b0.rd_en}, 32'h0);
    step();
    b0.start = 0;
    chk("restart_c1", {28'h0, b0.rd_en, b0.rd_addr, b0.wr_en},
        {28'h0, 1'b1, 2'd0, 1'b0});
    step();
    chk("no_stale_c2", {31'h0, b0.wr_en}, 32'h0);
    step();
    chk("first_wr_c3", {29'h0, b0.wr_en, b0.wr_addr},
        {29'h0, 1'b1, 2'd0});
    repeat (12) step();
    chk("idle_after", {30'h0, b0.busy, b0.rd_en}, 32'h0);

    // CNU_LAT=3: isolated row 0, then rows 1..3 and long drain
    for (int c = 0; c <= 17; c++) begin
      b1.start    = (c == 0);
      b1.max_iter = 6'd1;
      b1.stall    = (c >= 2 && c <= 7);
      b1.syn_ok   = 1'b0;
      #1;
      if (c >= 1) begin
        e_ce = (c >= 2 && c <= 4) || (c >= 9 && c <= 13);
        e_we = (c == 5) || (c >= 12 && c <= 14);
        e_wa = (c == 12) ? 2'd1 : (c == 13) ? 2'd2
             : (c == 14) ? 2'd3 : 2'd0;
        e_bz = (c <= 15);
        e_dn = (c == 16);
        wa_a = e_we ? b1.wr_addr : e_wa;
        chk($sformatf("lat3_c%0d", c),
            {26'h0, b1.cnu_en, b1.wr_en, wa_a, b1.busy, b1.done},
            {26'h0, e_ce, e_we, e_wa, e_bz, e_dn});
      end
      step();
    end
    b1.start = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
